// File: rtl/game_pkg.sv
// Shared types and constants for the game display blocks.
// Banner geometry and blink timing defaults live here so the top and FSM agree.
package game_pkg;

  typedef enum logic [1:0] {IDLE, BLINK, HOLD} banner_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int BANNER_ROM_ROWS      = 16;
  localparam int BANNER_ROW_BITS      = 65;
  localparam int BANNER_SCALE_LOG2    = 2;
  localparam int BANNER_X0            = 190;
  localparam int BANNER_Y0            = 208;
  localparam int BANNER_BLINK_FRAMES  = 30;
  localparam int BANNER_BLINK_TOGGLES = 6;

endpackage

// File: rtl/banner_blink_fsm.sv
// Blink-then-hold sequencer for the win banner, counted in frames.
// Produces the frame-aligned visible flag and the active (not idle) flag.
module banner_blink_fsm
  import game_pkg::*;
#(
  parameter int BLINK_FRAMES  = BANNER_BLINK_FRAMES,
  parameter int BLINK_TOGGLES = BANNER_BLINK_TOGGLES
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic win,
  input  logic clear,
  input  logic frame_start,
  output logic visible,
  output logic active
);

  localparam int FW = $clog2(BLINK_FRAMES);
  localparam int TW = $clog2(BLINK_TOGGLES + 1);

  banner_state_t state, state_nxt;
  logic [FW-1:0] frame_cnt, frame_nxt;
  logic [TW-1:0] toggle_cnt, toggle_nxt;
  logic          visible_nxt;
  logic          last_frame;

  assign last_frame = (frame_cnt == FW'(BLINK_FRAMES - 1));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      toggle_cnt <= '0;
      visible    <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_cnt  <= frame_nxt;
      toggle_cnt <= toggle_nxt;
      visible    <= visible_nxt;
    end
  end

  // clear wins over everything; win outside IDLE never restarts the sequence
  always_comb begin
    state_nxt   = state;
    frame_nxt   = frame_cnt;
    toggle_nxt  = toggle_cnt;
    visible_nxt = visible;
    if (clear) begin
      state_nxt   = IDLE;
      frame_nxt   = '0;
      toggle_nxt  = '0;
      visible_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win) begin
            state_nxt   = BLINK;
            frame_nxt   = '0;
            toggle_nxt  = '0;
            visible_nxt = 1'b1;
          end
        end
        BLINK: begin
          if (frame_start) begin
            if (last_frame) begin
              frame_nxt  = '0;
              toggle_nxt = toggle_cnt + TW'(1);
              if (toggle_cnt == TW'(BLINK_TOGGLES - 1)) begin
                state_nxt   = HOLD;
                visible_nxt = 1'b1;
              end else begin
                visible_nxt = ~visible;
              end
            end else begin
              frame_nxt = frame_cnt + FW'(1);
            end
          end
        end
        HOLD: begin
          visible_nxt = 1'b1;
        end
        default: begin
          state_nxt   = IDLE;
          visible_nxt = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    active = (state != IDLE);
  end

endmodule

// File: rtl/win_banner_ctrl.sv
// Win banner controller: blink sequencing plus a 2-stage pixel pipeline that
// maps DrawX/DrawY onto the external banner ROM and emits banner_on.
module win_banner_ctrl
  import game_pkg::*;
#(
  parameter int ROM_ROWS      = BANNER_ROM_ROWS,
  parameter int ROW_BITS      = BANNER_ROW_BITS,
  parameter int SCALE_LOG2    = BANNER_SCALE_LOG2,
  parameter int X0            = BANNER_X0,
  parameter int Y0            = BANNER_Y0,
  parameter int BLINK_FRAMES  = BANNER_BLINK_FRAMES,
  parameter int BLINK_TOGGLES = BANNER_BLINK_TOGGLES
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        win,
  input  logic                        clear,
  input  logic                        frame_start,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  output logic [$clog2(ROM_ROWS)-1:0] rom_addr,
  input  logic [ROW_BITS-1:0]         rom_data,
  output logic                        banner_on,
  output logic                        active
);

  localparam int AW   = $clog2(ROM_ROWS);
  localparam int COLW = $clog2(ROW_BITS);

  logic            visible;
  logic [10:0]     dx, dy;
  logic            in_region;
  logic [COLW-1:0] col;
  logic            v1;
  logic            pix;

  banner_blink_fsm #(
    .BLINK_FRAMES (BLINK_FRAMES),
    .BLINK_TOGGLES(BLINK_TOGGLES)
  ) u_blink (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .win        (win),
    .clear      (clear),
    .frame_start(frame_start),
    .visible    (visible),
    .active     (active)
  );

  // Offsets are 11-bit two's complement; bit 10 set means left of / above the banner.
  assign dx = {1'b0, DrawX} - 11'(X0);
  assign dy = {1'b0, DrawY} - 11'(Y0);
  assign in_region = !dx[10] && (dx[9:0] < 10'(ROW_BITS << SCALE_LOG2)) &&
                     !dy[10] && (dy[9:0] < 10'(ROM_ROWS << SCALE_LOG2));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      col      <= '0;
      v1       <= 1'b0;
    end else begin
      if (in_region) begin
        rom_addr <= dy[SCALE_LOG2 +: AW];
      end
      col <= dx[SCALE_LOG2 +: COLW];
      v1  <= in_region & visible;
    end
  end

  // v1 gates the ROM bit select so an out-of-range column never reaches rom_data.
  always_comb begin
    pix = 1'b0;
    if (v1 && (col < COLW'(ROW_BITS))) begin
      pix = rom_data[COLW'(ROW_BITS - 1) - col];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      banner_on <= 1'b0;
    end else begin
      banner_on <= pix;
    end
  end

endmodule

// File: tb/tb_win_banner_ctrl.sv
// Self-checking bench for win_banner_ctrl: hand-derived vector table, directed
// blink/reset sequences and randomized traffic against a frame-count model.
module tb_win_banner_ctrl;

  localparam int X0 = 190;
  localparam int Y0 = 208;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        win = 1'b0;
  logic        clear = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [3:0]  rom_addr;
  logic [64:0] rom_data;
  logic        banner_on;
  logic        active;

  logic [64:0] rom [16];

  int vectors = 0;
  int miscompares = 0;

  bit m_won = 1'b0;
  int m_frames = 0;
  bit m_s1 = 1'b0;
  bit exp_on = 1'b0;
  int m_addr = 0;

  win_banner_ctrl dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .win        (win),
    .clear      (clear),
    .frame_start(frame_start),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .banner_on  (banner_on),
    .active     (active)
  );

  assign rom_data = rom[rom_addr];

  always #5 Clk = ~Clk;

  typedef struct {
    bit rst_n;
    bit w;
    bit c;
    bit fs;
    int x;
    int y;
    bit e_on;
    bit e_act;
    int e_addr;
  } vec_t;

  vec_t tbl[15];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Visibility from frames since the win: 30-frame halves, solid after 6 toggles.
  function automatic bit model_visible();
    if (!m_won) return 1'b0;
    if (m_frames >= 180) return 1'b1;
    return ((m_frames / 30) % 2) == 0;
  endfunction

  task automatic apply_stimulus(input bit rst_n, input bit w, input bit c, input bit fs,
                                input int x, input int y);
    bit in_reg;
    bit vis_now;
    logic [64:0] row;
    Reset_n     = rst_n;
    win         = w;
    clear       = c;
    frame_start = fs;
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    in_reg  = (x >= X0) && (x < X0 + 260) && (y >= Y0) && (y < Y0 + 64);
    vis_now = model_visible();
    if (!rst_n) begin
      exp_on   = 1'b0;
      m_s1     = 1'b0;
      m_addr   = 0;
      m_won    = 1'b0;
      m_frames = 0;
    end else begin
      exp_on = m_s1;
      m_s1   = 1'b0;
      if (in_reg) begin
        m_addr = (y - Y0) / 4;
        row    = rom[m_addr];
        m_s1   = vis_now && row[64 - (x - X0) / 4];
      end
      if (c) begin
        m_won    = 1'b0;
        m_frames = 0;
      end else if (w && !m_won) begin
        m_won    = 1'b1;
        m_frames = 0;
      end else if (fs && m_won) begin
        m_frames++;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic check_output();
    check_val("banner_on", 32'(banner_on), 32'(exp_on));
    check_val("active", 32'(active), 32'(m_won));
    check_val("rom_addr", 32'(rom_addr), 32'(m_addr));
  endtask

  initial begin
    for (int r = 0; r < 16; r++) begin
      rom[r] = {$urandom, $urandom, $urandom};
    end
    rom[0][64]  = 1'b1;
    rom[1][64]  = 1'b1;
    rom[2][64]  = 1'b1;
    rom[2][0]   = 1'b1;
    rom[15][64] = 1'b1;

    tbl[0]  = '{0, 0, 0, 0, 0,        0,       0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0,        0,       0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0,        0,       0, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, X0,       Y0 + 8,  0, 1, 2};
    tbl[4]  = '{1, 0, 0, 0, X0,       Y0 + 8,  0, 1, 2};
    tbl[5]  = '{1, 0, 0, 0, X0 + 259, Y0 + 8,  1, 1, 2};
    tbl[6]  = '{1, 0, 0, 0, X0 + 260, Y0 + 8,  1, 1, 2};
    tbl[7]  = '{1, 0, 0, 0, X0,       Y0 + 3,  0, 1, 0};
    tbl[8]  = '{1, 0, 0, 0, X0,       Y0 + 4,  1, 1, 1};
    tbl[9]  = '{1, 0, 0, 0, X0 - 1,   Y0 + 4,  1, 1, 1};
    tbl[10] = '{1, 0, 0, 0, X0,       Y0 + 63, 0, 1, 15};
    tbl[11] = '{1, 0, 0, 0, X0,       Y0 + 64, 1, 1, 15};
    tbl[12] = '{1, 1, 1, 0, 0,        0,       0, 0, 15};
    tbl[13] = '{1, 0, 0, 0, X0,       Y0,      0, 0, 0};
    tbl[14] = '{1, 0, 0, 0, X0,       Y0,      0, 0, 0};

    $display("[TB] vector table");
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(tbl[i].rst_n, tbl[i].w, tbl[i].c, tbl[i].fs, tbl[i].x, tbl[i].y);
      check_val($sformatf("tbl%0d_on", i), 32'(banner_on), 32'(tbl[i].e_on));
      check_val($sformatf("tbl%0d_act", i), 32'(active), 32'(tbl[i].e_act));
      check_val($sformatf("tbl%0d_addr", i), 32'(rom_addr), 32'(tbl[i].e_addr));
    end

    $display("[TB] idle frame sweep");
    for (int y = 0; y < 480; y += 8) begin
      for (int x = 0; x < 640; x += 4) begin
        apply_stimulus(1, 0, 0, 0, x, y);
        check_output();
      end
    end

    $display("[TB] blink and hold sequence");
    apply_stimulus(1, 0, 1, 0, X0, Y0 + 8);
    apply_stimulus(1, 1, 0, 0, X0, Y0 + 8);
    check_output();
    for (int i = 0; i < 29; i++) begin
      apply_stimulus(1, 0, 0, 1, X0, Y0 + 8);
      check_output();
    end
    repeat (2) apply_stimulus(1, 0, 0, 0, X0, Y0 + 8);
    check_val("blink_pre_on", 32'(banner_on), 32'd1);
    apply_stimulus(1, 0, 0, 1, X0, Y0 + 8);
    repeat (2) apply_stimulus(1, 0, 0, 0, X0, Y0 + 8);
    check_val("blink_off", 32'(banner_on), 32'd0);
    check_val("blink_act", 32'(active), 32'd1);
    for (int i = 0; i < 150; i++) begin
      apply_stimulus(1, 0, 0, 1, X0, Y0 + 8);
      check_output();
    end
    repeat (2) apply_stimulus(1, 0, 0, 0, X0, Y0 + 8);
    check_val("hold_on", 32'(banner_on), 32'd1);
    check_val("hold_act", 32'(active), 32'd1);
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1, i[0], 0, 1, X0, Y0 + 8);
      check_output();
    end
    repeat (2) apply_stimulus(1, 0, 0, 0, X0, Y0 + 8);
    check_val("hold_stay_on", 32'(banner_on), 32'd1);

    $display("[TB] reset mid-blink");
    apply_stimulus(1, 0, 1, 0, X0, Y0 + 8);
    apply_stimulus(1, 1, 0, 0, X0, Y0 + 8);
    for (int i = 0; i < 10; i++) apply_stimulus(1, 0, 0, 1, X0, Y0 + 8);
    check_output();
    apply_stimulus(0, 0, 0, 0, X0, Y0 + 8);
    check_val("rst_on", 32'(banner_on), 32'd0);
    check_val("rst_act", 32'(active), 32'd0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, 0, 0, 1, X0, Y0 + 8);
      check_output();
    end
    check_val("post_rst_on", 32'(banner_on), 32'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus(($urandom % 700) != 0, ($urandom % 50) == 0, ($urandom % 300) == 0,
                     ($urandom % 3) == 0,
                     X0 - 8 + int'($urandom_range(0, 275)),
                     Y0 - 4 + int'($urandom_range(0, 71)));
      check_output();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/win_banner_ctrl.md
Name: win_banner_ctrl

Overview:
- Sequences the "win" banner ROM (16 rows x 65 bits, MSB = leftmost pixel) onto the VGA pixel stream.
- On a game-win event it runs a blink-then-hold display sequence, counted in frames.
- Each cycle it maps the current DrawX/DrawY to a ROM row address and bit index, and outputs a registered banner_on pixel flag to the colour mapper.
- Sits between game-state logic, the VGA controller and the banner ROM.

Parameters:
ROM_ROWS, 16, rows in banner ROM (address width = 4)
ROW_BITS, 65, bits per ROM row
SCALE_LOG2, 2, each ROM bit drawn as (2^SCALE_LOG2)x(2^SCALE_LOG2) pixels
X0, 190, left edge of banner in pixels
Y0, 208, top edge of banner in pixels
BLINK_FRAMES, 30, frames per blink half-period
BLINK_TOGGLES, 6, visibility toggles before entering HOLD

Ports:
Clk  in  1  pixel-domain clock
Reset_n  in  1  synchronous active-low reset
win  in  1  one-cycle pulse from game logic: player has won
clear  in  1  one-cycle pulse: new game, remove banner
frame_start  in  1  one-cycle pulse at start of each frame (vsync)
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
rom_addr  out  4  address to banner ROM
rom_data  in  65  combinational ROM row for rom_addr
banner_on  out  1  draw banner colour at the pixel presented 2 cycles earlier
active  out  1  FSM not in IDLE

Behaviour:
- Reset (Reset_n low at a Clk edge): state=IDLE; rom_addr=0, banner_on=0, active=0; frame counter=0, toggle counter=0, visible=0; pipeline valid bits=0. Reset mid-sequence aborts immediately.
- FSM states IDLE, BLINK, HOLD:
  - IDLE: on win go to BLINK, with visible=1, frame_cnt=0, toggle_cnt=0.
  - BLINK: on each frame_start, frame_cnt++. When frame_cnt reaches BLINK_FRAMES-1 on a frame_start, frame_cnt is cleared, visible is inverted and toggle_cnt++. When the toggle that makes toggle_cnt==BLINK_TOGGLES occurs, go to HOLD with visible=1.
  - HOLD: visible=1 until clear.
  - Any state: clear returns to IDLE with visible=0. clear has priority over win and frame_start in the same cycle.
  - win in BLINK or HOLD is ignored; it does not restart the sequence.
- active = (state != IDLE), registered.
- Pixel pipeline (latency exactly 2 cycles, one pixel per cycle):
  - Stage 1: dx = DrawX - X0 and dy = DrawY - Y0, computed at 11 bits signed. in_region = dx>=0 && dx<ROW_BITS<<SCALE_LOG2 && dy>=0 && dy<ROM_ROWS<<SCALE_LOG2.
  - Stage 1 registers: rom_addr <= dy>>SCALE_LOG2 (truncated to 4 bits); col <= dx>>SCALE_LOG2 (7 bits); v1 <= in_region & visible.
  - Stage 1 out of region: rom_addr holds its previous value and v1=0.
  - Stage 2 registers: banner_on <= v1 & rom_data[ROW_BITS-1-col]. An index outside 0..ROW_BITS-1 is unreachable when v1=1; it must still not produce X (guard with v1).
- Boundaries:
  - Last column: dx = ROW_BITS*4-1 = 259 is inside; 260 is outside.
  - Last row: dy = 63 is inside, giving rom_addr=15.
  - DrawX < X0 wraps negative and is treated as outside, never as a large positive value.
- visible changes only on frame_start edges or reset/clear/win. A toggle therefore never tears mid-frame, except on clear/win, which take effect on the next cycle.

Decomposition:
- Shared package (game_pkg): typedef enum logic [1:0] {IDLE, BLINK, HOLD} banner_state_t; constants for screen width/height (640/480).
- Sub-module banner_blink_fsm (state, frame and toggle counters, visible). The parent keeps the 2-stage pixel pipeline and the ROM interface. The ROM itself stays a separate instance outside this block.

Test Plan:
1. Reset held low 3 cycles, then released -> banner_on=0, active=0, rom_addr=0. Sweep a full frame of pixels -> banner_on never 1.
2. win pulse, then DrawY=Y0+8, DrawX=X0 with a model ROM row 2 whose MSB=1 -> rom_addr=2 after 1 cycle, banner_on=1 after 2 cycles. DrawX=X0+259 -> bit 0 selected. DrawX=X0+260 -> banner_on=0.
3. After win, 30 frame_start pulses -> visible goes to 0; 180 pulses total -> state HOLD, visible=1, active=1. Further frame_start pulses -> no change.
4. clear and win in the same cycle during BLINK -> IDLE, banner_on=0 two cycles later. A later win -> restarts at BLINK with toggle_cnt=0.
5. Reset_n low mid-BLINK with DrawX/DrawY inside the banner -> banner_on=0 and active=0 on the next cycle, and both stay low until a new win.
6. Scale check: SCALE_LOG2=2, DrawY=Y0+3 vs Y0+4 -> rom_addr 0 vs 1. DrawX=X0-1 (wrap) -> banner_on=0.
